// File: rtl/traffic_vehicle_detector.sv
// Vehicle-detector conditioning: per-road sync, debounce, presence stretch and stuck flag,
// followed by a minimum-dwell filter producing the light controller's 2-bit demand code.
module traffic_vehicle_detector #(
    parameter int unsigned DEB_CYCLES   = 3,
    parameter int unsigned HOLD_CYCLES  = 5,
    parameter int unsigned MIN_DWELL    = 10,
    parameter int unsigned STUCK_CYCLES = 120
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       veh_main_raw,
    input  logic       veh_side_raw,
    output logic [1:0] sw,
    output logic       sw_chg,
    output logic       fault_main,
    output logic       fault_side
);
    localparam int unsigned DW  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HW  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned SCW = $clog2(STUCK_CYCLES + 1);
    localparam int unsigned WW  = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;

    localparam logic [DW-1:0]  DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [SCW-1:0] STUCK_MAX = SCW'(STUCK_CYCLES);
    localparam logic [WW-1:0]  DWELL_MAX = WW'(MIN_DWELL);

    // Lane index 1 is the main road, 0 the trunk road, matching the bit order of sw.
    logic [1:0]     raw;
    logic [1:0]     s1_q, s2_q;
    logic [1:0]     deb_q, deb_d;
    logic [1:0]     fault_q, fault_d;
    logic [1:0]     pres;
    logic [DW-1:0]  dcnt_q [2];
    logic [DW-1:0]  dcnt_d [2];
    logic [HW-1:0]  hcnt_q [2];
    logic [HW-1:0]  hcnt_d [2];
    logic [SCW-1:0] scnt_q [2];
    logic [SCW-1:0] scnt_d [2];

    logic [1:0]     sw_q, sw_d;
    logic           chg_q, chg_d;
    logic [WW-1:0]  wcnt_q, wcnt_d;

    assign raw = {veh_main_raw, veh_side_raw};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i]  = deb_q[i];
            dcnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end

            hcnt_d[i] = hcnt_q[i];
            if (deb_q[i]) begin
                hcnt_d[i] = HOLD_MAX;
            end else if (hcnt_q[i] != '0) begin
                hcnt_d[i] = hcnt_q[i] - 1'b1;
            end

            scnt_d[i] = '0;
            if (deb_q[i]) begin
                scnt_d[i] = (scnt_q[i] == STUCK_MAX) ? scnt_q[i] : scnt_q[i] + 1'b1;
            end

            // Gated by deb so the flag drops on the first edge after deb falls.
            fault_d[i] = deb_q[i] & (scnt_q[i] == STUCK_MAX);
            pres[i]    = deb_q[i] | (hcnt_q[i] != '0);
        end
    end

    always_comb begin
        wcnt_d = (wcnt_q == DWELL_MAX) ? wcnt_q : wcnt_q + 1'b1;
        sw_d   = sw_q;
        chg_d  = 1'b0;
        if ((pres != sw_q) && (wcnt_q == DWELL_MAX)) begin
            sw_d   = pres;
            chg_d  = 1'b1;
            wcnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            deb_q   <= '0;
            fault_q <= '0;
            dcnt_q  <= '{default: '0};
            hcnt_q  <= '{default: '0};
            scnt_q  <= '{default: '0};
            sw_q    <= '0;
            chg_q   <= 1'b0;
            wcnt_q  <= DWELL_MAX;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            fault_q <= fault_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            scnt_q  <= scnt_d;
            sw_q    <= sw_d;
            chg_q   <= chg_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign sw         = sw_q;
    assign sw_chg     = chg_q;
    assign fault_main = fault_q[1];
    assign fault_side = fault_q[0];

endmodule

// File: tb/tb_traffic_vehicle_detector.sv
// Bench for traffic_vehicle_detector: directed scenarios plus random detector traffic,
// every cycle checked against a time-stamp based reference model.
module tb_traffic_vehicle_detector;
    localparam int unsigned DEB   = 3;
    localparam int unsigned HOLD  = 5;
    localparam int unsigned DWELL = 10;
    localparam int unsigned STUCK = 120;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       veh_main_raw = 1'b0;
    logic       veh_side_raw = 1'b0;
    logic [1:0] sw;
    logic       sw_chg;
    logic       fault_main;
    logic       fault_side;

    int compared   = 0;
    int mismatched = 0;

    traffic_vehicle_detector #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
        .MIN_DWELL   (DWELL),
        .STUCK_CYCLES(STUCK)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .veh_main_raw(veh_main_raw),
        .veh_side_raw(veh_side_raw),
        .sw          (sw),
        .sw_chg      (sw_chg),
        .fault_main  (fault_main),
        .fault_side  (fault_side)
    );

    always #5 sys_clk = ~sys_clk;

    // Model state: edge counter, debounced level, rise/fall time stamps, raw sample history.
    int       n = 0;
    bit       mdeb   [2];
    int       mrise  [2];
    int       mfall  [2];
    bit       mhist  [2][16];
    bit       mpres  [2];
    bit       mfault [2];
    bit [1:0] msw;
    bit       mchg;
    int       mlast;

    task automatic model_edge(input bit m, input bit s, input bit r);
        bit [1:0] cand;
        bit       rv [2];
        bit       flip;
        rv[1] = m;
        rv[0] = s;
        n++;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                mdeb[i]   = 1'b0;
                mrise[i]  = 0;
                mfall[i]  = -1000000;
                mpres[i]  = 1'b0;
                mfault[i] = 1'b0;
                for (int k = 0; k < 16; k++) mhist[i][k] = 1'b0;
            end
            msw   = 2'b00;
            mchg  = 1'b0;
            mlast = -1000000;
        end else begin
            cand = {mpres[1], mpres[0]};
            mchg = (cand != msw) && (n - mlast > int'(DWELL));
            if (mchg) begin
                msw   = cand;
                mlast = n;
            end
            for (int i = 0; i < 2; i++) begin
                mfault[i] = mdeb[i] && (n - mrise[i] > int'(STUCK));
                for (int k = 15; k > 0; k--) mhist[i][k] = mhist[i][k-1];
                mhist[i][0] = rv[i];
                // Two-flop sync delay: the debouncer sees the raw sample from two edges back.
                flip = 1'b1;
                for (int k = 0; k < int'(DEB); k++) begin
                    if (mhist[i][2+k] == mdeb[i]) flip = 1'b0;
                end
                if (flip) begin
                    mdeb[i] = !mdeb[i];
                    if (mdeb[i]) mrise[i] = n;
                    else mfall[i] = n;
                end
                mpres[i] = mdeb[i] || (n - mfall[i] < int'(HOLD));
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic tick(input bit m, input bit s, input bit r);
        @(negedge sys_clk);
        veh_main_raw = m;
        veh_side_raw = s;
        sys_rst      = r;
        @(posedge sys_clk);
        model_edge(m, s, r);
        #1;
        chk("sw", {30'd0, sw}, {30'd0, msw});
        chk("sw_chg", {31'd0, sw_chg}, {31'd0, mchg});
        chk("fault_main", {31'd0, fault_main}, {31'd0, mfault[1]});
        chk("fault_side", {31'd0, fault_side}, {31'd0, mfault[0]});
    endtask

    task automatic idle(input int cycles);
        for (int t = 0; t < cycles; t++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int  cnt;
        int  first_t;
        int  c1;
        int  gap;
        bit  seen;
        bit  partial;
        int  seg_m;
        int  seg_s;
        bit  lm;
        bit  ls;

        // Reset held with both detectors active.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("rst_sw", {30'd0, sw}, 32'd0);
        chk("rst_chg", {31'd0, sw_chg}, 32'd0);
        for (int t = 1; t <= 6; t++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (t == 5) chk("rst_pre_sw", {30'd0, sw}, 32'd0);
        end
        chk("rst_post_sw", {30'd0, sw}, 32'd3);
        idle(30);

        // Short glitch on main must be swallowed.
        cnt = 0;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            tick(1'b0, 1'b0, 1'b0);
            cnt += int'(sw_chg);
        end
        chk("glitch_chg_count", cnt, 32'd0);
        chk("glitch_sw", {30'd0, sw}, 32'd0);

        // Four-cycle main pulse is accepted.
        cnt = 0;
        for (int t = 1; t <= 14; t++) begin
            tick(t <= 4, 1'b0, 1'b0);
            cnt += int'(sw_chg);
            if (t == 6) chk("pulse_sw", {30'd0, sw}, 32'd2);
        end
        chk("pulse_chg_count", cnt, 32'd1);
        idle(30);

        // Trunk hold stretch after release.
        for (int t = 0; t < 20; t++) tick(1'b0, 1'b1, 1'b0);
        for (int t = 1; t <= 11; t++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (t == 10) chk("hold_last_high", {31'd0, sw[0]}, 32'd1);
            if (t == 11) chk("hold_low", {31'd0, sw[0]}, 32'd0);
        end
        idle(30);

        // Dwell: trunk arrives shortly after main was granted.
        seen = 1'b0;
        c1   = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (sw_chg) begin
                seen = 1'b1;
                c1   = n;
            end
        end
        chk("dwell_first_chg", {31'd0, seen}, 32'd1);
        for (int t = 0; t < 3; t++) tick(1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        gap  = 0;
        for (int t = 0; t < 30 && !seen; t++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (sw_chg) begin
                seen = 1'b1;
                gap  = n - c1;
            end
        end
        chk("dwell_gap", gap, 32'd11);
        chk("dwell_sw", {30'd0, sw}, 32'd3);
        idle(40);

        // Both roads rise on the same edge.
        cnt     = 0;
        partial = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick(1'b1, 1'b1, 1'b0);
            cnt += int'(sw_chg);
            if (sw == 2'b01 || sw == 2'b10) partial = 1'b1;
        end
        chk("simul_chg_count", cnt, 32'd1);
        chk("simul_partial", {31'd0, partial}, 32'd0);
        chk("simul_sw", {30'd0, sw}, 32'd3);
        idle(40);

        // Stuck trunk sensor.
        first_t = 0;
        for (int t = 1; t <= 200; t++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (fault_side && first_t == 0) first_t = t;
        end
        chk("stuck_rise_t", first_t, 32'd126);
        chk("stuck_sw0", {31'd0, sw[0]}, 32'd1);
        first_t = 0;
        for (int t = 1; t <= 20; t++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (!fault_side && first_t == 0) first_t = t;
        end
        chk("stuck_clear_t", first_t, 32'd6);
        idle(20);

        // Random segmented traffic with occasional mid-run resets.
        seg_m = 0;
        seg_s = 0;
        lm    = 1'b0;
        ls    = 1'b0;
        for (int t = 0; t < 1500; t++) begin
            if (seg_m == 0) begin
                lm    = 1'($urandom_range(0, 1));
                seg_m = int'($urandom_range(1, 12));
            end
            if (seg_s == 0) begin
                ls    = 1'($urandom_range(0, 1));
                seg_s = int'($urandom_range(1, 12));
            end
            seg_m--;
            seg_s--;
            tick(lm, ls, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
